// File: rtl/freq_gate_ctrl.sv
// -----------------------------------------------------------------------------
// freq_gate_ctrl
//
// Gate-window controller for the frequency-measurement path. On an accepted
// start it configures and arms the edge detector, waits for the first detected
// edge, opens a GATE_CYCLES-long window aligned to that edge, counts detector
// ticks inside the window (saturating), and publishes the result with a
// one-cycle done pulse.
//
// Optional feature macro: FREQ_GATE_TIMEOUT_EN
//   When defined, the SYNC wait is bounded by TIMEOUT_CYCLES and a measurement
//   with no edge ends with count=0, overflow=0, timeout=1. When undefined, no
//   timer is built and timeout_o is tied low.
//
// Ports:
//   clk_i        system clock, rising edge
//   rst_i        synchronous active-high reset
//   start_i      single-cycle measurement request (sampled only in IDLE)
//   edge_sel_i   1 = rising, 0 = falling; latched when start is accepted
//   tick_i       edge pulse from the edge detector
//   det_type_o   edge type for the detector's type input
//   det_rst_n_o  active-low detector reset, low whenever not measuring
//   busy_o       high from the cycle after start is accepted through DONE
//   done_o       one-cycle result-valid pulse
//   count_o      ticks counted in the last window, held until the next done
//   overflow_o   the last window's count saturated
//   timeout_o    the last measurement ended without any edge
// -----------------------------------------------------------------------------
module freq_gate_ctrl #(
    parameter int GATE_CYCLES    = 50_000_000,
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 100_000_000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             edge_sel_i,
    input  logic             tick_i,
    output logic             det_type_o,
    output logic             det_rst_n_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] count_o,
    output logic             overflow_o,
    output logic             timeout_o
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ARM  = 3'd1,
        S_SYNC = 3'd2,
        S_GATE = 3'd3,
        S_DONE = 3'd4
    } state_e;

    localparam int               GT_W      = $clog2(GATE_CYCLES);
    localparam logic [GT_W-1:0]  GATE_LAST = GT_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    // Elaboration-time configuration guards.
    if (GATE_CYCLES < 2) begin : g_bad_gate
        $error("freq_gate_ctrl: GATE_CYCLES must be at least 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("freq_gate_ctrl: TIMEOUT_CYCLES must be at least 1");
    end

    // Saturating increment: returns {overflow, count}. Once the counter sits
    // at its maximum, a further tick is lost and flags the overflow.
    function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                               input logic             ovf,
                                               input logic             tick);
        logic [CNT_W:0] res;
        if (!tick) begin
            res = {ovf, cnt};
        end else if (cnt == CNT_MAX) begin
            res = {1'b1, cnt};
        end else begin
            res = {ovf, cnt + {{(CNT_W-1){1'b0}}, 1'b1}};
        end
        return res;
    endfunction

    state_e           state_q, state_d;
    logic             arm_q, arm_d;             // second ARM cycle marker
    logic [GT_W-1:0]  gate_tmr_q, gate_tmr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             det_type_q, det_type_d;
    logic             det_rst_n_q, det_rst_n_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W:0]   inc_s;

`ifdef FREQ_GATE_TIMEOUT_EN
    localparam int              TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] to_tmr_q, to_tmr_d;
    logic            timeout_q, timeout_d;
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        arm_d      = arm_q;
        gate_tmr_d = gate_tmr_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        det_type_d = det_type_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        inc_s      = sat_inc(cnt_q, ovf_q, tick_i);
`ifdef FREQ_GATE_TIMEOUT_EN
        to_tmr_d   = to_tmr_q;
        timeout_d  = timeout_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d    = S_ARM;
                    det_type_d = edge_sel_i;
                    arm_d      = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ARM: begin
                // Two cycles with the detector out of reset; ticks ignored.
                if (arm_q) begin
                    state_d = S_SYNC;
`ifdef FREQ_GATE_TIMEOUT_EN
                    to_tmr_d = '0;
`endif
                end else begin
                    arm_d = 1'b1;
                end
            end
            S_SYNC: begin
                // The aligning edge itself is not counted. It also wins over
                // a timeout expiring in the same cycle.
                if (tick_i) begin
                    state_d    = S_GATE;
                    gate_tmr_d = '0;
                    cnt_d      = '0;
                    ovf_d      = 1'b0;
                end
`ifdef FREQ_GATE_TIMEOUT_EN
                else if (to_tmr_q == TO_LAST) begin
                    state_d    = S_DONE;
                    count_d    = '0;
                    overflow_d = 1'b0;
                    timeout_d  = 1'b1;
                end else begin
                    to_tmr_d = to_tmr_q + {{(TO_W-1){1'b0}}, 1'b1};
                end
`else
                else begin
                    state_d = S_SYNC;
                end
`endif
            end
            S_GATE: begin
                cnt_d = inc_s[CNT_W-1:0];
                ovf_d = inc_s[CNT_W];
                if (gate_tmr_q == GATE_LAST) begin
                    // Publish including a tick in the final gate cycle.
                    state_d    = S_DONE;
                    count_d    = inc_s[CNT_W-1:0];
                    overflow_d = inc_s[CNT_W];
`ifdef FREQ_GATE_TIMEOUT_EN
                    timeout_d  = 1'b0;
`endif
                end else begin
                    gate_tmr_d = gate_tmr_q + {{(GT_W-1){1'b0}}, 1'b1};
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status outputs are registered from the next state so they line up
        // with the state they describe.
        busy_d      = (state_d != S_IDLE);
        det_rst_n_d = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            arm_q       <= 1'b0;
            gate_tmr_q  <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            det_type_q  <= 1'b1;
            det_rst_n_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
`ifdef FREQ_GATE_TIMEOUT_EN
            to_tmr_q    <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            arm_q       <= arm_d;
            gate_tmr_q  <= gate_tmr_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            det_type_q  <= det_type_d;
            det_rst_n_q <= det_rst_n_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
`ifdef FREQ_GATE_TIMEOUT_EN
            to_tmr_q    <= to_tmr_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    assign det_type_o  = det_type_q;
    assign det_rst_n_o = det_rst_n_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign count_o     = count_q;
    assign overflow_o  = overflow_q;
`ifdef FREQ_GATE_TIMEOUT_EN
    assign timeout_o   = timeout_q;
`else
    assign timeout_o   = 1'b0;
`endif

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// -----------------------------------------------------------------------------
// tb_freq_gate_ctrl
//
// Self-checking bench for freq_gate_ctrl (GATE_CYCLES=100, CNT_W=4,
// TIMEOUT_CYCLES=50). A measurement is described as per-cycle tick/start
// streams indexed from the cycle start is accepted (cycle 0). Expected done
// cycle, count and flags come either from a hand-computed table or from a
// reference model that scans the tick stream for the aligning edge and counts
// the ticks in the following window.
// -----------------------------------------------------------------------------
module tb_freq_gate_ctrl;

    localparam int G    = 100;
    localparam int CW   = 4;
    localparam int TO   = 50;
    localparam int MAXC = 1200;
    localparam int CMAX = 15;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic          edge_sel_i;
    logic          tick_i;
    logic          det_type_o;
    logic          det_rst_n_o;
    logic          busy_o;
    logic          done_o;
    logic [CW-1:0] count_o;
    logic          overflow_o;
    logic          timeout_o;

    freq_gate_ctrl #(
        .GATE_CYCLES    (G),
        .CNT_W          (CW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .edge_sel_i  (edge_sel_i),
        .tick_i      (tick_i),
        .det_type_o  (det_type_o),
        .det_rst_n_o (det_rst_n_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .count_o     (count_o),
        .overflow_o  (overflow_o),
        .timeout_o   (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit es;        // edge_sel at start
        int off;       // first tick at cycle 3+off
        int period;    // later ticks every period cycles
        int exp_done;  // expected DONE cycle
        int exp_cnt;
        bit exp_ovf;
    } vec_t;

    vec_t tbl[8];
    bit   tick_arr[MAXC];
    bit   start_arr[MAXC];

    int n_tests = 0;
    int n_fail  = 0;
    int h_cnt   = 0;   // last published results
    bit h_ovf   = 1'b0;
    bit h_to    = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_arrays();
        for (int i = 0; i < MAXC; i++) begin
            tick_arr[i]  = 1'b0;
            start_arr[i] = 1'b0;
        end
    endtask

    task automatic fill_row(input vec_t v);
        int t;
        clear_arrays();
        t = 3 + v.off;
        tick_arr[1] = 1'b1;              // ARM ticks must be ignored
        tick_arr[2] = 1'b1;
        tick_arr[t] = 1'b1;
        for (int c = t + v.period; c < MAXC; c += v.period) tick_arr[c] = 1'b1;
        start_arr[0]          = 1'b1;
        start_arr[1]          = 1'b1;    // ignored in ARM
        start_arr[50]         = 1'b1;    // ignored in SYNC/GATE
        start_arr[v.exp_done] = 1'b1;    // ignored in DONE
    endtask

    task automatic reset_holds();
        h_cnt = 0;
        h_ovf = 1'b0;
        h_to  = 1'b0;
    endtask

    // Reference: find the aligning edge (or timeout), then count the window.
    task automatic model(output int d, output int cnt, output bit ov, output bit to);
        int t;
        int n;
        t = -1;
        for (int c = 3; c < MAXC; c++) begin
`ifdef FREQ_GATE_TIMEOUT_EN
            if (c >= 3 + TO) break;
`endif
            if (tick_arr[c]) begin
                t = c;
                break;
            end
        end
        if (t < 0) begin
            d = 3 + TO; cnt = 0; ov = 1'b0; to = 1'b1;
        end else begin
            n = 0;
            for (int c = t + 1; c <= t + G; c++) n += int'(tick_arr[c]);
            d   = t + G + 1;
            cnt = (n > CMAX) ? CMAX : n;
            ov  = (n > CMAX);
            to  = 1'b0;
        end
    endtask

    // Drive one measurement from the streams and check every cycle through
    // the first IDLE cycle after DONE.
    task automatic run_stream(input bit es, input int d_exp, input int c_exp,
                              input bit o_exp, input bit to_exp);
        int n;
        for (int c = 0; c <= d_exp; c++) begin
            start_i    = start_arr[c];
            tick_i     = tick_arr[c];
            edge_sel_i = (c == 0) ? es : 1'($urandom_range(0, 1));
            cyc();
            n = c + 1;
            check("busy",      32'(busy_o),      32'(n <= d_exp));
            check("det_rst_n", 32'(det_rst_n_o), 32'(n <= d_exp));
            check("done",      32'(done_o),      32'(n == d_exp));
            check("det_type",  32'(det_type_o),  32'(es));
            if (n >= d_exp) begin
                check("count",    32'(count_o),    32'(c_exp));
                check("overflow", 32'(overflow_o), 32'(o_exp));
                check("timeout",  32'(timeout_o),  32'(to_exp));
            end else begin
                check("count_hold",    32'(count_o),    32'(h_cnt));
                check("overflow_hold", 32'(overflow_o), 32'(h_ovf));
                check("timeout_hold",  32'(timeout_o),  32'(h_to));
            end
        end
        h_cnt   = c_exp;
        h_ovf   = o_exp;
        h_to    = to_exp;
        start_i = 1'b0;
        tick_i  = 1'b0;
    endtask

    task automatic check_idle(input string nm);
        check({nm, "_busy"},      32'(busy_o),      32'd0);
        check({nm, "_done"},      32'(done_o),      32'd0);
        check({nm, "_det_rst_n"}, 32'(det_rst_n_o), 32'd0);
        check({nm, "_det_type"},  32'(det_type_o),  32'd1);
        check({nm, "_count"},     32'(count_o),     32'd0);
        check({nm, "_overflow"},  32'(overflow_o),  32'd0);
        check({nm, "_timeout"},   32'(timeout_o),   32'd0);
    endtask

    initial begin
        int d;
        int cnt;
        bit ov;
        bit to;
        int p;
        bit es;

        tbl[0] = '{1'b1, 0,  10,  104, 10, 1'b0};
        tbl[1] = '{1'b0, 5,  10,  109, 10, 1'b0};
        tbl[2] = '{1'b1, 0,  2,   104, 15, 1'b1};
        tbl[3] = '{1'b0, 2,  7,   106, 14, 1'b0};
        tbl[4] = '{1'b1, 10, 6,   114, 15, 1'b1};
        tbl[5] = '{1'b0, 0,  100, 104, 1,  1'b0};
        tbl[6] = '{1'b1, 0,  101, 104, 0,  1'b0};
        tbl[7] = '{1'b1, 7,  15,  111, 6,  1'b0};

        // Reset values.
        rst_i = 1'b1; start_i = 1'b0; tick_i = 1'b0; edge_sel_i = 1'b0;
        cyc();
        cyc();
        check_idle("reset");
        rst_i = 1'b0;

        // Directed table.
        for (int i = 0; i < 8; i++) begin
            fill_row(tbl[i]);
            run_stream(tbl[i].es, tbl[i].exp_done, tbl[i].exp_cnt, tbl[i].exp_ovf, 1'b0);
        end

        // Reset in the middle of GATE, then a clean measurement.
        clear_arrays();
        start_arr[0] = 1'b1;
        for (int c = 3; c < MAXC; c += 3) tick_arr[c] = 1'b1;
        edge_sel_i = 1'b0;
        for (int c = 0; c < 30; c++) begin
            start_i = start_arr[c];
            tick_i  = tick_arr[c];
            cyc();
        end
        check("midgate_busy_before", 32'(busy_o), 32'd1);
        rst_i = 1'b1; start_i = 1'b0; tick_i = 1'b1;
        cyc();
        check_idle("midgate_rst");
        rst_i = 1'b0; tick_i = 1'b0;
        reset_holds();
        fill_row(tbl[3]);
        run_stream(tbl[3].es, tbl[3].exp_done, tbl[3].exp_cnt, tbl[3].exp_ovf, 1'b0);

`ifdef FREQ_GATE_TIMEOUT_EN
        // No edge: timeout after TO SYNC cycles.
        clear_arrays();
        start_arr[0] = 1'b1;
        run_stream(1'b1, 3 + TO, 0, 1'b0, 1'b1);
        // Edge on the final timeout cycle wins; timeout clears.
        fill_row('{1'b0, TO - 1, 10, TO + 2 + G + 1, 10, 1'b0});
        run_stream(1'b0, TO + 2 + G + 1, 10, 1'b0, 1'b0);
`else
        // No edge: SYNC waits indefinitely.
        start_i = 1'b1; edge_sel_i = 1'b1;
        cyc();
        start_i = 1'b0;
        for (int c = 1; c < 1000; c++) begin
            check("no_timeout_done", 32'(done_o), 32'd0);
            check("no_timeout_busy", 32'(busy_o), 32'd1);
            cyc();
        end
        rst_i = 1'b1;
        cyc();
        check_idle("no_timeout_rst");
        rst_i = 1'b0;
        reset_holds();
`endif

        // Randomized measurements against the reference model.
        for (int m = 0; m < 25; m++) begin
            p  = int'($urandom_range(0, 100));
            es = 1'($urandom_range(0, 1));
            clear_arrays();
            for (int c = 0; c < 3; c++) tick_arr[c] = 1'($urandom_range(0, 1));
            d = 3 + int'($urandom_range(0, 40));
            tick_arr[d] = 1'b1;
            for (int c = d + 1; c < MAXC; c++)
                tick_arr[c] = (int'($urandom_range(0, 99)) < p);
            start_arr[0] = 1'b1;
            for (int c = 1; c < MAXC; c++)
                start_arr[c] = ($urandom_range(0, 19) == 0);
            model(d, cnt, ov, to);
            run_stream(es, d, cnt, ov, to);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/freq_gate_ctrl.md
# freq_gate_ctrl

Gate-window controller for the frequency-measurement path. It configures and arms the edge detector, aligns a fixed-length gate window to the first detected edge, counts detector ticks inside the window, and publishes a saturating count with a one-cycle `done` pulse. It sits between the control/UI logic, which issues `start`, and the edge detector, which supplies `tick`.

## Interface
- `GATE_CYCLES`, default 50_000_000: gate window length in `clk` cycles (≥2).
- `CNT_W`, default 32: width of the tick counter and of `count`.
- `TIMEOUT_CYCLES`, default 100_000_000: SYNC wait limit; used only with the macro.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle request; sampled only in IDLE.
- `edge_sel`  in  1  1 = rising, 0 = falling; latched when `start` is accepted.
- `tick`  in  1  edge pulse from the edge detector.
- `det_type`  out  1  edge type driven to the detector's `type` input.
- `det_rst_n`  out  1  active-low detector reset; low whenever the block is not measuring.
- `busy`  out  1  high from the cycle after `start` is accepted through the DONE cycle.
- `done`  out  1  one-cycle pulse; `count`, `overflow` and `timeout` are valid on it.
- `count`  out  CNT_W  ticks counted in the last gate window; held until the next `done`.
- `overflow`  out  1  the last window's count saturated.
- `timeout`  out  1  the last measurement ended with no edge (always 0 without the macro).

## Operation
- States: IDLE, ARM, SYNC, GATE, DONE.
- IDLE: `det_rst_n`=0. `start`=1 → ARM; `edge_sel` is latched into `det_type`.
- ARM: lasts exactly 2 cycles with `det_rst_n`=1 so the detector leaves its init state. Ticks are ignored. Then → SYNC.
- SYNC: waits for the first `tick`. That tick is not counted. `tick`=1 → GATE with the gate timer and tick counter cleared.
- GATE: lasts exactly GATE_CYCLES cycles.
  - Each cycle with `tick`=1 increments the tick counter.
  - The counter saturates at 2^CNT_W−1 and sets an internal overflow flag.
  - The tick in the last gate cycle is counted. Then → DONE.
- DONE: lasts one cycle. `done`=1. `count`, `overflow` and `timeout` are updated in the same cycle. Then → IDLE.
- `start` outside IDLE is ignored, with no queuing.
- `det_type` holds its latched value until the next accepted `start`.
- Reset at any point: state → IDLE. All outputs take their reset values and any in-progress measurement is discarded.

## Timing
- Reset values: `det_type`=1, `det_rst_n`=0, `busy`=0, `done`=0, `count`=0, `overflow`=0, `timeout`=0.
- Cycle numbering starts at `start` sampled in cycle 0.
  - ARM: cycles 1–2.
  - SYNC: from cycle 3.
  - First tick at cycle t → GATE covers cycles t+1 … t+GATE_CYCLES, and DONE is cycle t+GATE_CYCLES+1.
- `done` and the new `count` are asserted in the same cycle. `busy` falls the cycle after `done`.
- The earliest accepted re-`start` is the cycle after DONE.

## Configuration
- With `FREQ_GATE_TIMEOUT_EN` defined:
  - SYNC has a wait timer.
  - If no tick arrives within TIMEOUT_CYCLES SYNC cycles → DONE with `count`=0, `overflow`=0, `timeout`=1.
  - If a tick arrives on the final timeout cycle, the tick wins and GATE starts normally.
  - `timeout` clears on the next successful `done`.
- Without the macro: SYNC waits indefinitely, no timer logic is built, and `timeout` is tied to 0.

## Test plan
- Basic count: GATE_CYCLES=100, `tick` every 10 cycles → `done` at t+101, `count`=10, `overflow`=0.
- Edge select: `start` with `edge_sel`=0 → `det_type`=0 from cycle 1 and held through DONE; `det_rst_n` is 0 in IDLE and 1 in ARM/SYNC/GATE/DONE.
- Busy lockout: `start` pulsed again during GATE and during DONE → ignored; exactly one `done`, `count` unchanged.
- Saturation: CNT_W=4, GATE_CYCLES=100, `tick` every 2 cycles → `count`=15, `overflow`=1.
- Timeout (macro on): TIMEOUT_CYCLES=50, no ticks → `done` at cycle 53, `count`=0, `timeout`=1. With the macro off → no `done` within 1000 cycles.
- Reset mid-GATE: `rst` for 1 cycle → next cycle IDLE, `busy`=0, `count`=0, `det_rst_n`=0. A following `start` measures correctly.
